// File: rtl/dac_table_deadlock_pkg.sv
// rtl/dac_table_deadlock_pkg.sv - shared constants and helpers for the DAC table deadlock watchdog
package dac_table_deadlock_pkg;

    localparam int DEF_THRESH = 16;
    localparam int DEF_EVT_W  = 16;

    // Source index encoding: stream bits first, then sub-instances.
    localparam int AXIS_BASE = 0;

    function automatic int inst_base(input int n_axis);
        return n_axis;
    endfunction

    // Width of a source index (src_idx_t) covering all streams and instances.
    function automatic int src_idx_w(input int n_axis, input int n_inst);
        int w;
        w = $clog2(n_axis + n_inst);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dac_table_deadlock_prio_enc.sv
// rtl/dac_table_deadlock_prio_enc.sv - lowest-set-bit priority encoder
module dac_table_deadlock_prio_enc #(
    parameter int W  = 4,
    parameter int IW = 2
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_table_deadlock_watchdog.sv
// rtl/dac_table_deadlock_watchdog.sv - persistent-stall watchdog; optional cause capture under DAC_TABLE_DEADLOCK_CAUSE_EN
module dac_table_deadlock_watchdog
    import dac_table_deadlock_pkg::*;
#(
    parameter int N_AXIS = 3,
    parameter int N_INST = 1,
    parameter int THRESH = DEF_THRESH,
    parameter int EVT_W  = DEF_EVT_W,
    localparam int IDX_W = src_idx_w(N_AXIS, N_INST)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_sticky,
    output logic [EVT_W-1:0]  block_events,
    output logic              cause_valid,
    output logic [IDX_W-1:0]  cause_idx
);

    localparam int              CW      = $clog2(THRESH + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(THRESH);
    localparam logic [CW-1:0]   CNT_ARM = CW'(THRESH - 1);
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    logic [N_INST-1:0] inst_eff;
    logic              any_blk;
    logic [CW-1:0]     cnt;
    logic              rise_q;

    // An instance that is idle is not considered stuck even if it reports blocked.
    assign inst_eff = inst_block_sigs & ~inst_idle_sigs;
    assign any_blk  = (|axis_block_sigs) | (|inst_eff);
    assign block    = (cnt == CNT_MAX);

    // Persistence counter; rise_q marks the cycle in which block has just gone high.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt    <= '0;
            rise_q <= 1'b0;
        end else begin
            if (any_blk) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
            rise_q <= any_blk && (cnt == CNT_ARM);
        end
    end

    // Sticky flag and saturating episode count; a rise beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            block_sticky <= 1'b0;
            block_events <= '0;
        end else if (rise_q) begin
            block_sticky <= 1'b1;
            if (clear) begin
                block_events <= EVT_W'(1);
            end else if (block_events != EVT_MAX) begin
                block_events <= block_events + EVT_W'(1);
            end
        end else if (clear) begin
            block_sticky <= 1'b0;
            block_events <= '0;
        end
    end

`ifdef DAC_TABLE_DEADLOCK_CAUSE_EN
    logic [N_AXIS+N_INST-1:0] src_vec;
    logic [IDX_W-1:0]         enc_idx;
    logic                     enc_valid;

    assign src_vec = {inst_eff, axis_block_sigs};

    dac_table_deadlock_prio_enc #(
        .W  (N_AXIS + N_INST),
        .IW (IDX_W)
    ) u_prio_enc (
        .vec   (src_vec),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // First-cause capture: only the first rise after reset/clear is recorded.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cause_valid <= 1'b0;
            cause_idx   <= '0;
        end else if (rise_q && (!cause_valid || clear) && enc_valid) begin
            cause_valid <= 1'b1;
            cause_idx   <= enc_idx;
        end else if (clear) begin
            cause_valid <= 1'b0;
            cause_idx   <= '0;
        end
    end
`else
    assign cause_valid = 1'b0;
    assign cause_idx   = '0;
`endif

endmodule

// File: doc/dac_table_deadlock_watchdog.md
# dac_table_deadlock_watchdog

Parametrised deadlock watchdog for the DAC table datapath. It replaces the fixed three-stream, one-instance monitor with one that takes configurable stream and sub-instance counts and adds a persistence threshold, a sticky flag, an episode counter and an optional first-cause capture. It sits beside the top-level DAC table instance, and its outputs go to the status/debug register block.

## Interface
- `N_AXIS`, default 3: number of AXI-stream block inputs (≥1).
- `N_INST`, default 1: number of sub-instance idle/block pairs (≥1).
- `THRESH`, default 16: consecutive blocked cycles required before `block` asserts (≥1; 1 gives the legacy behaviour).
- `EVT_W`, default 16: width of the episode counter.
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `axis_block_sigs`  in  N_AXIS: per-stream stall indication.
- `inst_idle_sigs`  in  N_INST: sub-instance idle.
- `inst_block_sigs`  in  N_INST: sub-instance blocked.
- `clear`  in  1: single-cycle clear of the sticky, episode and cause state.
- `block`  out  1: deadlock currently detected.
- `block_sticky`  out  1: a deadlock has been seen since the last clear.
- `block_events`  out  EVT_W: number of `block` rising edges since the last clear; saturates at all-ones.
- `cause_valid`  out  1: `cause_idx` holds a capture.
- `cause_idx`  out  IDX_W = $clog2(N_AXIS+N_INST): source of the first episode.

## Operation
- Raw condition: `any_blk` = OR of `axis_block_sigs` OR OR of (`inst_block_sigs` & ~`inst_idle_sigs`). A blocked instance that is also idle does not count.
- Persistence counter `cnt`, width $clog2(THRESH+1):
  - `any_blk`=1: `cnt` increments and saturates at THRESH.
  - `any_blk`=0: `cnt` returns to 0 on the next edge.
- `block` = (`cnt` == THRESH), decoded from the registered counter.
- States are implicit in `cnt`:
  - IDLE: `cnt`=0.
  - ARMING: 0<`cnt`<THRESH.
  - BLOCKED: `cnt`=THRESH.
  - Any deassertion of `any_blk` returns the block to IDLE.
- Rising edge of `block` (the edge where `cnt` goes THRESH-1→THRESH), called `rise`:
  - `block_sticky` is set.
  - `block_events` increments (saturating).
- `clear`:
  - `block_sticky`, `block_events`, `cause_valid` and `cause_idx` go to 0.
  - `cnt` and `block` are unaffected.
  - `clear` and `rise` in the same cycle: sticky set wins, `block_events` becomes 1, and capture occurs.
  - `clear` while `block` is held high with no `rise` that cycle: sticky clears and stays clear until the next `rise`.
- Reset (`reset_n`=0 at an edge): `cnt`, `block`, `block_sticky`, `block_events`, `cause_valid` and `cause_idx` all go to 0. This includes reset in mid-ARMING and in mid-BLOCKED.

## Timing
- `any_blk` constant 1 from edge t onward: `block` is high after edge t+THRESH-1, which is THRESH cycles of latency. THRESH=1 gives one cycle.
- `any_blk` falls at edge t: `block` is low after edge t.
- `any_blk` pulse of THRESH-1 cycles: no `block`, no sticky.
- Flags and counters update one edge after `rise`, so `block_sticky` rises together with `block`'s next edge.
- No handshake; all inputs are sampled every cycle.

## Configuration
- `DAC_TABLE_DEADLOCK_CAUSE_EN` defined:
  - On the first `rise` after a reset or clear, the lowest-indexed source that is asserted in that cycle is captured into `cause_idx`, and `cause_valid` is set.
  - Source encoding: indices 0..N_AXIS-1 are the stream bits; N_AXIS+k is instance k (effective block only).
  - Later episodes do not overwrite the capture until `clear`.
- Undefined: `cause_valid` and `cause_idx` are tied to 0 and no capture logic is built. The ports remain so the interface is stable.

## Structure
- Package `dac_table_deadlock_pkg` holds:
  - the default THRESH and EVT_W constants;
  - a `src_idx_t` width helper;
  - the source-index encoding constants (AXIS base 0, INST base N_AXIS).
- One sub-module, `dac_table_deadlock_prio_enc`: a parametrised lowest-set-bit priority encoder (vector in, index and valid out). It is instantiated only under the macro.

## Test plan
- Stream stall, THRESH=16: `axis_block_sigs`=3'b010 held for 20 cycles → `block` high from cycle 16 to 20, low one edge after release; `block_events`=1; `block_sticky`=1.
- Short pulse: `axis_block_sigs[0]` high for 15 cycles → `block`, `block_sticky` and `block_events` stay 0.
- Idle masking: `inst_block_sigs`=1 with `inst_idle_sigs`=1 for 40 cycles → no block. Drop idle → `block` after 16 cycles.
- Cause capture (macro on): streams 2 and instance 0 asserted together → `cause_idx`=2, `cause_valid`=1. A second episode on instance 0 → `cause_idx` stays 2 and `block_events`=2.
- Clear and saturation: EVT_W=2, 5 episodes → `block_events`=3. `clear` on a `rise` cycle → `block_events`=1, `block_sticky`=1.
- Reset mid-BLOCKED: `reset_n`=0 for 1 cycle while blocked → all outputs 0 next edge; with the stall still present, `block` re-asserts after 16 cycles.
